tmr_fault_monitor: RTL and testbench

Consumes the per-core fault flags and disagreement signal from the TMR triple voter and turns them into filtered, persistent health information. It implements a per-core health state machine with a persistence filter, recovery timer, saturating confirmed-fault counters, sticky transient/fault history and a multi-fault alarm. It drives the board's fault and disagreement LEDs with solid, blink and pulse-stretch patterns. It sits between the voter outputs and the top-level LED pins.

---
 rtl/tmr_fault_monitor_pkg.sv | 17 +
 rtl/tmr_core_health.sv | 113 +++++++++++
 rtl/tmr_fault_monitor.sv | 92 +++++++++
 tb/tb_tmr_fault_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tmr_fault_monitor_pkg.sv
// Shared definitions for the TMR fault monitor: per-core state encoding and
// the bit position of each core in the voter's flag vector.
package tmr_fault_monitor_pkg;

    typedef enum logic [1:0] {
        ST_HEALTHY    = 2'b00,
        ST_SUSPECT    = 2'b01,
        ST_FAULTED    = 2'b10,
        ST_RECOVERING = 2'b11
    } core_state_t;

    localparam int unsigned CORE_A    = 2;
    localparam int unsigned CORE_B    = 1;
    localparam int unsigned CORE_C    = 0;
    localparam int unsigned NUM_CORES = 3;

endpackage

// File: rtl/tmr_core_health.sv
// Health tracking for one TMR core: persistence/recovery FSM with timer,
// saturating confirmed-fault counter and sticky transient/fault history.
module tmr_core_health
    import tmr_fault_monitor_pkg::*;
#(
    parameter int unsigned PERSIST_CYCLES = 4,
    parameter int unsigned RECOVER_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag,
    input  logic                 clear,
    output core_state_t          state,
    output logic                 fault_entry,
    output logic [CNT_WIDTH-1:0] fault_count,
    output logic                 transient_seen,
    output logic                 fault_seen
);

    localparam int unsigned TMAX = (PERSIST_CYCLES > RECOVER_CYCLES) ? PERSIST_CYCLES : RECOVER_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] PERSIST_LAST = TW'(PERSIST_CYCLES - 1);
    localparam logic [TW-1:0] RECOVER_LAST = TW'(RECOVER_CYCLES - 1);

    core_state_t   state_n;
    logic [TW-1:0] timer, timer_n;
    logic          enter_faulted;
    logic          transient_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HEALTHY;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // timer holds the number of consecutive samples already taken in the
    // current SUSPECT/RECOVERING run, so the Nth sample is seen at N-1.
    always_comb begin
        state_n       = state;
        timer_n       = timer;
        fault_entry   = 1'b0;
        transient_set = 1'b0;
        unique case (state)
            ST_HEALTHY: begin
                if (flag) begin
                    if (PERSIST_CYCLES == 1) begin
                        state_n     = ST_FAULTED;
                        fault_entry = 1'b1;
                    end else begin
                        state_n = ST_SUSPECT;
                        timer_n = TW'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                if (flag) begin
                    if (timer == PERSIST_LAST) begin
                        state_n     = ST_FAULTED;
                        fault_entry = 1'b1;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end else begin
                    state_n       = ST_HEALTHY;
                    transient_set = 1'b1;
                end
            end
            ST_FAULTED: begin
                if (!flag) begin
                    if (RECOVER_CYCLES == 1) begin
                        state_n = ST_HEALTHY;
                    end else begin
                        state_n = ST_RECOVERING;
                        timer_n = TW'(1);
                    end
                end
            end
            ST_RECOVERING: begin
                if (flag) begin
                    state_n = ST_FAULTED;
                end else if (timer == RECOVER_LAST) begin
                    state_n = ST_HEALTHY;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = ST_HEALTHY;
        endcase
        enter_faulted = (state_n == ST_FAULTED) && (state != ST_FAULTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_count    <= '0;
            transient_seen <= 1'b0;
            fault_seen     <= 1'b0;
        end else if (clear) begin
            fault_count    <= '0;
            transient_seen <= 1'b0;
            fault_seen     <= 1'b0;
        end else begin
            if (fault_entry && (fault_count != '1)) fault_count <= fault_count + CNT_WIDTH'(1);
            if (transient_set) transient_seen <= 1'b1;
            if (enter_faulted) fault_seen <= 1'b1;
        end
    end

endmodule

// File: rtl/tmr_fault_monitor.sv
// Filters TMR voter fault flags into per-core health state and drives the
// fault/disagreement LEDs (solid, blink and pulse-stretch patterns).
module tmr_fault_monitor
    import tmr_fault_monitor_pkg::*;
#(
    parameter int unsigned PERSIST_CYCLES = 4,
    parameter int unsigned RECOVER_CYCLES = 16,
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned BLINK_LOG2     = 22,
    parameter int unsigned STRETCH_CYCLES = 1000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CORES-1:0]           fault_flags,
    input  logic                           disagreement,
    input  logic                           clear,
    output logic [NUM_CORES-1:0]           fault_led,
    output logic                           disagree_led,
    output logic [2*NUM_CORES-1:0]         core_state,
    output logic [NUM_CORES*CNT_WIDTH-1:0] fault_counts,
    output logic                           multi_fault
);

    localparam int unsigned SW = $clog2(STRETCH_CYCLES + 1);

    core_state_t            st [NUM_CORES];
    logic [NUM_CORES-1:0]   fault_entry;
    logic [NUM_CORES-1:0]   transient_seen;
    logic [NUM_CORES-1:0]   fault_seen;
    logic [NUM_CORES-1:0]   is_faulted;
    logic [BLINK_LOG2-1:0]  prescaler;
    logic [SW-1:0]          stretch_cnt;
    logic                   blink;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        tmr_core_health #(
            .PERSIST_CYCLES (PERSIST_CYCLES),
            .RECOVER_CYCLES (RECOVER_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_core (
            .clk            (clk),
            .rst            (rst),
            .flag           (fault_flags[i]),
            .clear          (clear),
            .state          (st[i]),
            .fault_entry    (fault_entry[i]),
            .fault_count    (fault_counts[i*CNT_WIDTH +: CNT_WIDTH]),
            .transient_seen (transient_seen[i]),
            .fault_seen     (fault_seen[i])
        );

        assign core_state[2*i +: 2] = st[i];
        assign is_faulted[i]        = (st[i] == ST_FAULTED);

        always_comb begin
            if (st[i] == ST_FAULTED || st[i] == ST_RECOVERING) fault_led[i] = 1'b1;
            else if (transient_seen[i] || fault_seen[i])       fault_led[i] = blink;
            else                                               fault_led[i] = 1'b0;
        end
    end

    // A confirmation can only happen on a high flag sample.
    always_comb assert ((fault_entry & ~fault_flags) == '0);

    assign blink = prescaler[BLINK_LOG2-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prescaler <= '0;
        else     prescaler <= prescaler + BLINK_LOG2'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch_cnt  <= '0;
            disagree_led <= 1'b0;
        end else begin
            if (disagreement)          stretch_cnt <= SW'(STRETCH_CYCLES);
            else if (stretch_cnt != '0) stretch_cnt <= stretch_cnt - SW'(1);
            disagree_led <= (stretch_cnt != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        multi_fault <= 1'b0;
        else if (clear) multi_fault <= 1'b0;
        else if ((is_faulted[CORE_A] & is_faulted[CORE_B]) |
                 (is_faulted[CORE_A] & is_faulted[CORE_C]) |
                 (is_faulted[CORE_B] & is_faulted[CORE_C]))
            multi_fault <= 1'b1;
    end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// Directed-vector bench for tmr_fault_monitor with small parameter values so
// blink, stretch and saturation behaviour are reachable in a few hundred cycles.
module tb_tmr_fault_monitor;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    fault_flags;
    logic          disagreement;
    logic          clear;
    logic [2:0]    fault_led;
    logic          disagree_led;
    logic [5:0]    core_state;
    logic [3*CW-1:0] fault_counts;
    logic          multi_fault;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned cyc         = 0;   // edges since reset release: reference for the blink phase

    tmr_fault_monitor #(
        .PERSIST_CYCLES (4),
        .RECOVER_CYCLES (8),
        .CNT_WIDTH      (CW),
        .BLINK_LOG2     (3),
        .STRETCH_CYCLES (5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fault_flags  (fault_flags),
        .disagreement (disagreement),
        .clear        (clear),
        .fault_led    (fault_led),
        .disagree_led (disagree_led),
        .core_state   (core_state),
        .fault_counts (fault_counts),
        .multi_fault  (multi_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic blink_ref();
        logic [31:0] c;
        c = cyc;
        return c[2];
    endfunction

    initial begin
        int unsigned highs;
        rst = 1'b1; fault_flags = '0; disagreement = 1'b0; clear = 1'b0;
        tick(2);
        check("rst_led",    {29'd0, fault_led}, 32'd0);
        check("rst_state",  {26'd0, core_state}, 32'd0);
        check("rst_counts", {20'd0, fault_counts}, 32'd0);
        check("rst_multi",  {31'd0, multi_fault}, 32'd0);
        check("rst_dled",   {31'd0, disagree_led}, 32'd0);
        rst = 1'b0;

        // Transient on A: three high samples, then low
        fault_flags = 3'b100;
        tick();
        check("t1_suspect", {30'd0, core_state[5:4]}, 32'd1);
        tick(2);
        check("t1_still_suspect", {30'd0, core_state[5:4]}, 32'd1);
        fault_flags = 3'b000;
        tick();
        check("t1_healthy", {30'd0, core_state[5:4]}, 32'd0);
        check("t1_countA",  {28'd0, fault_counts[11:8]}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            check("t1_blinkA", {31'd0, fault_led[2]}, {31'd0, blink_ref()});
            tick();
        end
        check("t1_ledBC", {30'd0, fault_led[1:0]}, 32'd0);

        // Confirm on B, interrupted recovery, then full recovery
        fault_flags = 3'b010;
        tick(3);
        check("t2_suspect", {30'd0, core_state[3:2]}, 32'd1);
        tick();
        check("t2_faulted", {30'd0, core_state[3:2]}, 32'd2);
        check("t2_countB",  {28'd0, fault_counts[7:4]}, 32'd1);
        check("t2_ledB",    {31'd0, fault_led[1]}, 32'd1);
        fault_flags = 3'b000;
        tick(5);
        check("t3_recov",   {30'd0, core_state[3:2]}, 32'd3);
        check("t3_ledB",    {31'd0, fault_led[1]}, 32'd1);
        fault_flags = 3'b010;
        tick();
        check("t3_refault", {30'd0, core_state[3:2]}, 32'd2);
        check("t3_countB",  {28'd0, fault_counts[7:4]}, 32'd1);
        fault_flags = 3'b000;
        tick(7);
        check("t2_recov7",  {30'd0, core_state[3:2]}, 32'd3);
        tick();
        check("t2_healthy", {30'd0, core_state[3:2]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            check("t2_blinkB", {31'd0, fault_led[1]}, {31'd0, blink_ref()});
            tick();
        end

        // Saturation on C: 20 full episodes, counter caps at 15
        for (int ep = 1; ep <= 20; ep++) begin
            fault_flags = 3'b001;
            tick(4);
            fault_flags = 3'b000;
            tick(8);
            check("t4_countC", {28'd0, fault_counts[3:0]}, (ep > 15) ? 32'd15 : ep);
        end
        check("t4_stateC", {30'd0, core_state[1:0]}, 32'd0);
        // 21st confirm coincident with clear: clear wins
        fault_flags = 3'b001;
        tick(3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_clr_countC", {28'd0, fault_counts[3:0]}, 32'd0);
        check("t4_clr_counts", {20'd0, fault_counts}, 32'd0);
        check("t4_clr_stateC", {30'd0, core_state[1:0]}, 32'd2);
        fault_flags = 3'b000;
        tick(8);
        check("t4_clr_leds", {29'd0, fault_led}, 32'd0);

        // Multi-fault on A and C, then clear
        fault_flags = 3'b101;
        tick(4);
        check("t5_states",   {26'd0, core_state}, 32'h22);
        check("t5_multi_lag",{31'd0, multi_fault}, 32'd0);
        tick();
        check("t5_multi",    {31'd0, multi_fault}, 32'd1);
        check("t5_counts",   {20'd0, fault_counts}, 32'h101);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_clr_multi",  {31'd0, multi_fault}, 32'd0);
        check("t5_clr_counts", {20'd0, fault_counts}, 32'd0);
        check("t5_clr_states", {26'd0, core_state}, 32'h22);
        check("t5_clr_leds",   {29'd0, fault_led}, 32'd5);
        tick();
        check("t5_multi_reset", {31'd0, multi_fault}, 32'd1);

        // One-cycle disagreement pulse
        disagreement = 1'b1;
        tick();
        disagreement = 1'b0;
        check("t6_dled_lag", {31'd0, disagree_led}, 32'd0);
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 0) check("t6_dled_first", {31'd0, disagree_led}, 32'd1);
            if (disagree_led) highs++;
        end
        check("t6_dled_len", highs, 32'd5);

        // Asynchronous reset while A is FAULTED
        check("t6_pre_rstA", {30'd0, core_state[5:4]}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_led",    {29'd0, fault_led}, 32'd0);
        check("t6_rst_state",  {26'd0, core_state}, 32'd0);
        check("t6_rst_counts", {20'd0, fault_counts}, 32'd0);
        check("t6_rst_multi",  {31'd0, multi_fault}, 32'd0);
        fault_flags = 3'b000;
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_stateA", {30'd0, core_state[5:4]}, 32'd0);
        check("t6_post_countA", {28'd0, fault_counts[11:8]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
